div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Sequential signed 32-bit integer divider for the MIPS-style datapath, the
//  inverse companion of the Booth multiplier. Writes quotient to lo and
//  remainder to hi (DIV semantics). Flags divide-by-zero to the control unit.
//  One restoring-division step per clock, driven by a level-held control line.
// PARAMETERS
//  DATA_W  32  operand/result width (a, b, hi, lo); iteration count = DATA_W
// PORTS
//  clock    in   1       system clock, all state on posedge
//  reset    in   1       synchronous, active-high
//  a        in   DATA_W  dividend (two's complement), sampled at start only
//  b        in   DATA_W  divisor (two's complement), sampled at start only
//  divCtrl  in   1       level request from control unit; held high for the op
//  hi       out  DATA_W  remainder (registered)
//  lo       out  DATA_W  quotient (registered)
//  done     out  1       one-cycle pulse: hi/lo valid or divZero raised
//  divZero  out  1       divisor was zero; sticky until next start or reset
// BEHAVIOUR
//  Reset: hi=0, lo=0, done=0, divZero=0, state=IDLE, internal regs cleared.
//   Reset wins over every other input, including mid-operation.
//  States: IDLE -> CALC -> SIGN -> HOLD -> IDLE.
//  IDLE: at edge E0 with divCtrl=1: latch sign_q=a[31]^b[31], sign_r=a[31],
//   magnitudes |a|,|b| (unsigned DATA_W; |0x80000000| = 0x80000000),
//   remainder acc=0, count=DATA_W, divZero<=0.
//   If b==0: divZero<=1, done<=1 at E0, hi/lo unchanged, go HOLD.
//   Else go CALC.
//  CALC (edges E1..E32): {acc,q} shifted left 1; trial = acc - |b| in DATA_W+1
//   bits; if trial >= 0 then acc=trial, q[0]=1 else q[0]=0. count-1;
//   at count reaching 0 go SIGN. divCtrl ignored in CALC.
//  SIGN (edge E33): lo <= sign_q ? -q : q; hi <= sign_r ? -acc : acc;
//   done <= 1; go HOLD. Quotient truncates toward zero; remainder takes the
//   dividend's sign; lo*b + hi == a always (mod 2^DATA_W).
//  Latency: hi/lo/done update at E33, i.e. 33 cycles after sampling edge E0.
//  HOLD: done <= 0 on the first edge in HOLD (done high exactly one cycle);
//   stay until divCtrl sampled 0, then IDLE. No restart while divCtrl held.
//  hi/lo retain last result until next SIGN or reset; never change in CALC.
//  Overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no flag.
//  divCtrl dropped during CALC: operation still completes; result delivered.
//  Reset mid-CALC: outputs zeroed, partial result discarded, IDLE next cycle.
// TESTING
//  1. a=100, b=7, divCtrl held -> at E33 lo=14, hi=2, done=1 for one cycle.
//  2. a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=-2 ->
//     lo=0xFFFFFFFD, hi=1; a=-7, b=-2 -> lo=3, hi=0xFFFFFFFF.
//  3. a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, divZero=0.
//  4. prior result lo=14/hi=2, then a=5, b=0 -> done=1 and divZero=1 at E0+1
//     cycle, hi=2/lo=14 unchanged; next valid op clears divZero.
//  5. reset asserted at E10 of an op -> hi=lo=0, done=0, divZero=0; a fresh
//     a=9, b=3 op afterwards gives lo=3, hi=0 at its E33.
//  6. divCtrl held 50 cycles after done -> exactly one done pulse, no new op;
//     drop for one cycle, raise with a=1, b=1 -> lo=1, hi=0 at new E33.

Source files
------------

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - control-unit <-> divider operand/result bundle
// Purpose: groups the divider's operands, request line and results.
// Signals:
//   a, b     dividend / divisor (two's complement), sampled at start
//   divCtrl  level-held request from the control unit
//   hi, lo   remainder / quotient (registered in the divider)
//   done     one-cycle completion pulse
//   divZero  divisor was zero (sticky until next start)
// Modports: master = control unit side, slave = divider side.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              divCtrl;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              done;
  logic              divZero;

  modport master (
    output a, b, divCtrl,
    input  hi, lo, done, divZero
  );

  modport slave (
    input  a, b, divCtrl,
    output hi, lo, done, divZero
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential signed restoring divider (DIV semantics)
// Purpose: one restoring-division step per clock on operand magnitudes,
//   then sign fix-up; quotient to lo, remainder to hi, divide-by-zero flag.
// Ports:
//   clock  system clock, all state on posedge
//   reset  synchronous, active-high
//   bus    div_unit_if.slave: a, b, divCtrl in; hi, lo, done, divZero out
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, HOLD} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] bmag_q;
  logic              sign_quo_q;
  logic              sign_rem_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              done_q;
  logic              div_zero_q;

  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] quo_d;

  always_comb begin
    // |0x80..0| stays 0x80..0, which is the correct unsigned magnitude.
    abs_a   = bus.a[DATA_W-1] ? -bus.a : bus.a;
    abs_b   = bus.b[DATA_W-1] ? -bus.b : bus.b;
    // {acc,q} shifted left; acc < |b| so the shifted value fits DATA_W+1 bits.
    shifted = {acc_q, quo_q[DATA_W-1]};
    trial   = shifted - {1'b0, bmag_q};
    acc_d   = shifted[DATA_W-1:0];
    quo_d   = {quo_q[DATA_W-2:0], 1'b0};
    if (!trial[DATA_W]) begin
      acc_d = trial[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      quo_q      <= '0;
      bmag_q     <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.divCtrl) begin
            sign_quo_q <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
            sign_rem_q <= bus.a[DATA_W-1];
            quo_q      <= abs_a;
            bmag_q     <= abs_b;
            acc_q      <= '0;
            count_q    <= CNT_W'(DATA_W);
            if (bus.b == '0) begin
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= HOLD;
            end else begin
              div_zero_q <= 1'b0;
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          quo_q   <= quo_d;
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          lo_q    <= sign_quo_q ? -quo_q : quo_q;
          hi_q    <= sign_rem_q ? -acc_q : acc_q;
          done_q  <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          // Wait for the request to be released so a held line cannot restart.
          done_q <= 1'b0;
          if (!bus.divCtrl) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.done    = done_q;
  assign bus.divZero = div_zero_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;

  div_unit_if #(.DATA_W(32)) dif ();

  div_unit #(.DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Signed DIV reference: 64-bit arithmetic avoids the 0x80000000/-1 overflow.
  function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endfunction

  // Transaction-level model: a start at E0 yields the result 33 edges later.
  logic [31:0] m_hi = '0, m_lo = '0, pq, pr;
  logic        m_done = 1'b0, m_dz = 1'b0, m_hold = 1'b0;
  int          pending = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
      pending = 0; m_hold = 1'b0;
    end else begin
      m_done = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          m_lo = pq; m_hi = pr; m_done = 1'b1; m_hold = 1'b1;
        end
      end else if (m_hold) begin
        if (!dif.divCtrl) m_hold = 1'b0;
      end else if (dif.divCtrl) begin
        m_dz = (dif.b == 32'd0);
        if (dif.b == 32'd0) begin
          m_done = 1'b1; m_hold = 1'b1;
        end else begin
          ref_div(dif.a, dif.b, pq, pr);
          pending = 33;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("cyc_hi", dif.hi, m_hi);
      check("cyc_lo", dif.lo, m_lo);
      check("cyc_done", {31'd0, dif.done}, {31'd0, m_done});
      check("cyc_divZero", {31'd0, dif.divZero}, {31'd0, m_dz});
    end
  end

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int hold_cycles,
                       output logic [31:0] lo_s, output logic [31:0] hi_s,
                       output logic dz_s, output int extra);
    logic got;
    dif.a = av; dif.b = bv; dif.divCtrl = 1'b1;
    got = 1'b0; extra = 0; lo_s = '0; hi_s = '0; dz_s = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (dif.done) begin
        got = 1'b1; lo_s = dif.lo; hi_s = dif.hi; dz_s = dif.divZero;
      end
      // Operands are only sampled at start; disturb them afterwards.
      dif.a = $urandom; dif.b = $urandom;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles a=%h b=%h", av, bv);
    end
    repeat (hold_cycles) begin
      @(negedge clock);
      if (dif.done) extra++;
    end
    dif.divCtrl = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] lo_s, hi_s, q, r, ra, rb;
    logic        dz_s;
    int          extra, got;

    dif.a = '0; dif.b = '0; dif.divCtrl = 1'b0;

    ref_div(32'd100, 32'd7, q, r);
    check("model_100_7_q", q, 32'd14);
    check("model_100_7_r", r, 32'd2);
    ref_div(32'hFFFFFFF9, 32'd2, q, r);
    check("model_m7_2_q", q, 32'hFFFFFFFD);
    check("model_m7_2_r", r, 32'hFFFFFFFF);
    ref_div(32'h80000000, 32'hFFFFFFFF, q, r);
    check("model_ovf_q", q, 32'h80000000);
    check("model_ovf_r", r, 32'd0);

    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    check("reset_hi", dif.hi, 32'd0);
    check("reset_lo", dif.lo, 32'd0);
    check("reset_done", {31'd0, dif.done}, 32'd0);
    check("reset_divZero", {31'd0, dif.divZero}, 32'd0);
    reset = 1'b0;

    do_op(32'd100, 32'd7, 0, lo_s, hi_s, dz_s, extra);
    check("t1_lo", lo_s, 32'd14);
    check("t1_hi", hi_s, 32'd2);
    check("t1_done_pulse", dif.done, 1'b0);

    do_op(32'hFFFFFFF9, 32'd2, 1, lo_s, hi_s, dz_s, extra);
    check("t2a_lo", lo_s, 32'hFFFFFFFD);
    check("t2a_hi", hi_s, 32'hFFFFFFFF);
    do_op(32'd7, 32'hFFFFFFFE, 0, lo_s, hi_s, dz_s, extra);
    check("t2b_lo", lo_s, 32'hFFFFFFFD);
    check("t2b_hi", hi_s, 32'd1);
    do_op(32'hFFFFFFF9, 32'hFFFFFFFE, 2, lo_s, hi_s, dz_s, extra);
    check("t2c_lo", lo_s, 32'd3);
    check("t2c_hi", hi_s, 32'hFFFFFFFF);

    do_op(32'h80000000, 32'hFFFFFFFF, 0, lo_s, hi_s, dz_s, extra);
    check("t3_lo", lo_s, 32'h80000000);
    check("t3_hi", hi_s, 32'd0);
    check("t3_divZero", {31'd0, dz_s}, 32'd0);

    do_op(32'd100, 32'd7, 0, lo_s, hi_s, dz_s, extra);
    do_op(32'd5, 32'd0, 0, lo_s, hi_s, dz_s, extra);
    check("t4_divZero", {31'd0, dz_s}, 32'd1);
    check("t4_lo_kept", lo_s, 32'd14);
    check("t4_hi_kept", hi_s, 32'd2);
    do_op(32'd9, 32'd3, 0, lo_s, hi_s, dz_s, extra);
    check("t4_divZero_clr", {31'd0, dz_s}, 32'd0);
    check("t4_next_lo", lo_s, 32'd3);

    dif.a = 32'd1000; dif.b = 32'd3; dif.divCtrl = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_hi", dif.hi, 32'd0);
    check("t5_lo", dif.lo, 32'd0);
    check("t5_done", {31'd0, dif.done}, 32'd0);
    check("t5_divZero", {31'd0, dif.divZero}, 32'd0);
    reset = 1'b0; dif.divCtrl = 1'b0;
    @(negedge clock);
    do_op(32'd9, 32'd3, 0, lo_s, hi_s, dz_s, extra);
    check("t5_lo_after", lo_s, 32'd3);
    check("t5_hi_after", hi_s, 32'd0);

    do_op(32'd20, 32'd4, 50, lo_s, hi_s, dz_s, extra);
    check("t6_lo", lo_s, 32'd5);
    check("t6_extra_done", 32'(extra), 32'd0);
    do_op(32'd1, 32'd1, 0, lo_s, hi_s, dz_s, extra);
    check("t6_restart_lo", lo_s, 32'd1);
    check("t6_restart_hi", hi_s, 32'd0);

    // Request dropped mid-calculation: the operation still completes.
    dif.a = 32'hFFFFFF9C; dif.b = 32'd9; dif.divCtrl = 1'b1;
    repeat (5) @(negedge clock);
    dif.divCtrl = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clock);
      if (dif.done) begin
        got = 1;
        check("t7_lo", dif.lo, 32'hFFFFFFF5);
        check("t7_hi", dif.hi, 32'hFFFFFFFF);
      end
    end
    check("t7_done_seen", 32'(got), 32'd1);
    @(negedge clock);

    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(0, 1) ? 32'd1 : 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 100));
        3:       rb = -32'($urandom_range(1, 1000));
        default: rb = $urandom;
      endcase
      do_op(ra, rb, $urandom_range(0, 3), lo_s, hi_s, dz_s, extra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
